// File: rtl/wr_stage.sv
// Writeback stage: buffers butterfly result pairs and serialises them onto a
// single-write-port coefficient RAM, tracking layer/transform completion.
module wr_stage #(
    parameter int DATA_W          = 12,
    parameter int ADDR_W          = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int SKID            = 6,
    parameter int PAIRS_PER_STAGE = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_e,
    input  logic              i_last_e,
    input  logic              i_done_e,
    input  logic [ADDR_W-1:0] i_addr_up_e,
    input  logic [ADDR_W-1:0] i_addr_dn_e,
    input  logic [DATA_W-1:0] i_bu_out_up_e,
    input  logic [DATA_W-1:0] i_bu_out_dn_e,
    input  logic [ADDR_W-1:0] i_chk_addr,
    output logic              o_hazard,
    output logic              o_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              o_busy,
    output logic              o_stage_done,
    output logic              o_last_stage_done,
    output logic              o_ntt_done,
    output logic              o_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(PAIRS_PER_STAGE + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr_up;
        logic [ADDR_W-1:0] addr_dn;
        logic [DATA_W-1:0] data_up;
        logic [DATA_W-1:0] data_dn;
        logic              last;
        logic              done;
    } pair_t;

    typedef enum logic [1:0] {IDLE, WR_UP, WR_DN} state_t;

    pair_t          fifo [FIFO_DEPTH];
    pair_t          hold;
    pair_t          in_pair;
    state_t         state;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [LW-1:0]  layer;
    logic           pop;
    logic           push;

    assign in_pair = '{addr_up: i_addr_up_e, addr_dn: i_addr_dn_e,
                       data_up: i_bu_out_up_e, data_dn: i_bu_out_dn_e,
                       last: i_last_e, done: i_done_e};

    // The writer takes a new pair only when the up/dn slots are free.
    assign pop  = ((state == IDLE) || (state == WR_DN)) && (count != '0);
    assign push = i_e && ((count != CW'(FIFO_DEPTH)) || pop);

    assign o_ready = (count <= CW'(FIFO_DEPTH - 1 - SKID));
    assign o_busy  = (count != '0) || (state != IDLE);

    always_comb begin
        logic [PW-1:0] off;
        o_hazard = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ((CW'(off) < count) &&
                ((fifo[i].addr_up == i_chk_addr) || (fifo[i].addr_dn == i_chk_addr)))
                o_hazard = 1'b1;
        end
        if ((state == WR_UP) && ((hold.addr_up == i_chk_addr) || (hold.addr_dn == i_chk_addr)))
            o_hazard = 1'b1;
        if ((state == WR_DN) && (hold.addr_dn == i_chk_addr))
            o_hazard = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            layer             <= '0;
            hold              <= '0;
            mem_we            <= 1'b0;
            mem_waddr         <= '0;
            mem_wdata         <= '0;
            o_stage_done      <= 1'b0;
            o_last_stage_done <= 1'b0;
            o_ntt_done        <= 1'b0;
            o_overflow        <= 1'b0;
        end else begin
            o_stage_done      <= 1'b0;
            o_last_stage_done <= 1'b0;
            o_ntt_done        <= 1'b0;

            if (push) begin
                fifo[wr_ptr] <= in_pair;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (i_e && !push)
                o_overflow <= 1'b1;
            if (pop) begin
                hold   <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);

            case (state)
                IDLE: begin
                    if (pop) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= fifo[rd_ptr].addr_up;
                        mem_wdata <= fifo[rd_ptr].data_up;
                        state     <= WR_UP;
                    end else begin
                        mem_we <= 1'b0;
                    end
                end
                WR_UP: begin
                    mem_we    <= 1'b1;
                    mem_waddr <= hold.addr_dn;
                    mem_wdata <= hold.data_dn;
                    state     <= WR_DN;
                end
                WR_DN: begin
                    // A done pair clears the layer count even mid-layer.
                    if (layer == LW'(PAIRS_PER_STAGE - 1)) begin
                        layer             <= '0;
                        o_stage_done      <= 1'b1;
                        o_last_stage_done <= hold.last;
                    end else begin
                        layer <= layer + 1'b1;
                    end
                    if (hold.done) begin
                        layer      <= '0;
                        o_ntt_done <= 1'b1;
                    end
                    if (pop) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= fifo[rd_ptr].addr_up;
                        mem_wdata <= fifo[rd_ptr].data_up;
                        state     <= WR_UP;
                    end else begin
                        mem_we <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_stage.sv
// Bench for wr_stage: a pair-level schedule model (write times derived from
// arrival times) is checked against the DUT every cycle, plus pinned literals.
module tb_wr_stage;

    localparam int DW = 12, AW = 8, DEPTH = 16, SKIDN = 6, PPS = 128;

    logic          clk = 1'b0;
    logic          rst, i_e, i_last_e, i_done_e;
    logic [AW-1:0] i_addr_up_e, i_addr_dn_e, i_chk_addr;
    logic [DW-1:0] i_bu_out_up_e, i_bu_out_dn_e;
    logic          o_hazard, o_ready, mem_we, o_busy;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          o_stage_done, o_last_stage_done, o_ntt_done, o_overflow;

    always #5 clk = ~clk;

    wr_stage #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .SKID(SKIDN),
               .PAIRS_PER_STAGE(PPS)) dut (
        .clk(clk), .rst(rst), .i_e(i_e), .i_last_e(i_last_e), .i_done_e(i_done_e),
        .i_addr_up_e(i_addr_up_e), .i_addr_dn_e(i_addr_dn_e),
        .i_bu_out_up_e(i_bu_out_up_e), .i_bu_out_dn_e(i_bu_out_dn_e),
        .i_chk_addr(i_chk_addr), .o_hazard(o_hazard), .o_ready(o_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .o_busy(o_busy), .o_stage_done(o_stage_done),
        .o_last_stage_done(o_last_stage_done), .o_ntt_done(o_ntt_done),
        .o_overflow(o_overflow)
    );

    // One accepted pair: arrival cycle and the cycle its up write is driven.
    // The dn write is always the cycle after the up write.
    typedef struct {
        int          push;
        int          up;
        logic [AW-1:0] au, ad;
        logic [DW-1:0] du, dd;
        bit          last, done;
    } mp_t;

    mp_t q[$];
    int  t = 0, prev_dn = -100, layer = 0;
    bit  m_ovf = 0, armed = 0;
    int  n_vec = 0, n_mis = 0;

    logic          s_we, s_busy, s_ready, s_ovf, s_haz, s_st, s_ls, s_nd;
    logic [AW-1:0] s_waddr;
    logic [DW-1:0] s_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    // Compare process: expectations come from the pair schedule only.
    always @(negedge clk) begin : cmp
        int  occ;
        bit  e_we, e_st, e_ls, e_nd, e_busy, e_haz, pop_next;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        mp_t p;
        if (armed) begin
            while (q.size() > 0 && q[0].up + 1 < t - 1) void'(q.pop_front());
            e_we = 0; e_st = 0; e_ls = 0; e_nd = 0; e_busy = 0; e_haz = 0;
            e_a = '0; e_d = '0; occ = 0;
            foreach (q[i]) begin
                if (q[i].up + 1 == t - 1) begin
                    layer++;
                    if (layer == PPS) begin layer = 0; e_st = 1; e_ls = q[i].last; end
                    if (q[i].done) begin layer = 0; e_nd = 1; end
                end
                if (q[i].up == t) begin e_we = 1; e_a = q[i].au; e_d = q[i].du; end
                if (q[i].up + 1 == t) begin e_we = 1; e_a = q[i].ad; e_d = q[i].dd; end
                if (t <= q[i].up + 1) e_busy = 1;
                if (t < q[i].up) occ++;
                if (t <= q[i].up && (i_chk_addr == q[i].au || i_chk_addr == q[i].ad)) e_haz = 1;
                if (t == q[i].up + 1 && i_chk_addr == q[i].ad) e_haz = 1;
            end
            chk("mem_we", mem_we, e_we);
            if (e_we) begin
                chk("mem_waddr", mem_waddr, e_a);
                chk("mem_wdata", mem_wdata, e_d);
            end
            chk("o_busy", o_busy, e_busy);
            chk("o_ready", o_ready, occ <= DEPTH - 1 - SKIDN);
            chk("o_hazard", o_hazard, e_haz);
            chk("o_stage_done", o_stage_done, e_st);
            chk("o_last_stage_done", o_last_stage_done, e_ls);
            chk("o_ntt_done", o_ntt_done, e_nd);
            chk("o_overflow", o_overflow, m_ovf);
        end
        s_we = mem_we; s_waddr = mem_waddr; s_wdata = mem_wdata; s_busy = o_busy;
        s_ready = o_ready; s_ovf = o_overflow; s_haz = o_hazard;
        s_st = o_stage_done; s_ls = o_last_stage_done; s_nd = o_ntt_done;
        if (rst) begin
            q.delete(); layer = 0; m_ovf = 0; prev_dn = -100; armed = 1;
        end else if (armed && i_e) begin
            occ = 0; pop_next = 0;
            foreach (q[i]) begin
                if (t < q[i].up) occ++;
                if (q[i].up == t + 1) pop_next = 1;
            end
            if (occ == DEPTH && !pop_next) begin
                m_ovf = 1;
            end else begin
                p.push = t; p.up = (t + 2 > prev_dn + 1) ? t + 2 : prev_dn + 1;
                p.au = i_addr_up_e; p.ad = i_addr_dn_e;
                p.du = i_bu_out_up_e; p.dd = i_bu_out_dn_e;
                p.last = i_last_e; p.done = i_done_e;
                q.push_back(p);
                prev_dn = p.up + 1;
            end
        end
        t++;
    end

    // Per-phase observation counters, owned by the stimulus process.
    int ph_we, ph_st, ph_ls, ph_nd, ph_all3, ph_haz, ph_nready, run, max_run;

    task automatic clr_ph();
        ph_we = 0; ph_st = 0; ph_ls = 0; ph_nd = 0; ph_all3 = 0;
        ph_haz = 0; ph_nready = 0; run = 0; max_run = 0;
    endtask

    task automatic cyc(input bit e, input bit last, input bit done,
                       input logic [AW-1:0] au, input logic [AW-1:0] ad,
                       input logic [DW-1:0] du, input logic [DW-1:0] dd);
        i_e = e; i_last_e = last; i_done_e = done;
        i_addr_up_e = au; i_addr_dn_e = ad; i_bu_out_up_e = du; i_bu_out_dn_e = dd;
        @(posedge clk); #1;
        if (s_we) begin ph_we++; run++; if (run > max_run) max_run = run; end
        else run = 0;
        ph_st += int'(s_st); ph_ls += int'(s_ls); ph_nd += int'(s_nd);
        ph_haz += int'(s_haz); ph_nready += int'(!s_ready);
        if (s_st && s_ls && s_nd) ph_all3++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1; idle(1); rst = 0; idle(1);
        chk("rst_mem_we", s_we, 0);
        chk("rst_mem_waddr", s_waddr, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_overflow", s_ovf, 0);
        chk("rst_ready", s_ready, 1);
    endtask

    task automatic rnd_pair(input bit last, input bit done);
        logic [AW-1:0] au, ad;
        logic [DW-1:0] du, dd;
        au = AW'($urandom); ad = AW'($urandom);
        du = DW'($urandom_range(0, 3328)); dd = DW'($urandom_range(0, 3328));
        cyc(1, last, done, au, ad, du, dd);
    endtask

    task automatic gated_layer(input bit last, input bit done_on_last);
        int issued, guard;
        issued = 0; guard = 0;
        while (issued < PPS && guard < 2000) begin
            guard++;
            if (o_ready) begin
                rnd_pair(last, done_on_last && issued == PPS - 1);
                issued++;
            end else idle(1);
        end
        chk("gated_issue_count", issued, PPS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1; i_chk_addr = 8'hFF;
        idle(2);
        do_reset();

        // Single pair: up at cycle 2, dn at cycle 3, idle by cycle 4.
        clr_ph();
        cyc(1, 0, 0, 8'h05, 8'h85, 12'd100, 12'd3000);
        idle(2);
        chk("single_up_we", s_we, 1);
        chk("single_up_addr", s_waddr, 8'h05);
        chk("single_up_data", s_wdata, 12'd100);
        idle(1);
        chk("single_dn_we", s_we, 1);
        chk("single_dn_addr", s_waddr, 8'h85);
        chk("single_dn_data", s_wdata, 12'd3000);
        idle(1);
        chk("single_busy_low", s_busy, 0);
        idle(4);
        chk("single_no_stage", ph_st + ph_nd, 0);

        // One full layer, upstream honouring o_ready.
        do_reset(); clr_ph();
        gated_layer(0, 0);
        idle(30);
        chk("layer_writes", ph_we, 2 * PPS);
        chk("layer_no_gaps", max_run, 2 * PPS);
        chk("layer_stage_pulses", ph_st, 1);
        chk("layer_ready_dropped", ph_nready > 0, 1);
        chk("layer_no_overflow", s_ovf, 0);

        // Ungated burst: drops start once the FIFO fills (36 of 40 survive).
        do_reset(); clr_ph();
        for (int k = 0; k < 40; k++) rnd_pair(0, 0);
        idle(100);
        chk("burst_overflow", s_ovf, 1);
        chk("burst_writes", ph_we, 72);

        // Final layer with done on the last pair.
        do_reset(); clr_ph();
        gated_layer(1, 1);
        idle(30);
        chk("final_stage", ph_st, 1);
        chk("final_last_stage", ph_ls, 1);
        chk("final_ntt", ph_nd, 1);
        chk("final_together", ph_all3, 1);
        // Layer count must restart from zero after done.
        clr_ph();
        gated_layer(0, 0);
        idle(30);
        chk("after_done_stage", ph_st, 1);

        // Hazard on the 3rd pair's dn address: pending for cycles 3..7.
        do_reset(); clr_ph();
        i_chk_addr = 8'h33;
        cyc(1, 0, 0, 8'h10, 8'h11, 12'd1, 12'd2);
        cyc(1, 0, 0, 8'h20, 8'h21, 12'd3, 12'd4);
        cyc(1, 0, 0, 8'h30, 8'h33, 12'd5, 12'd6);
        idle(10);
        chk("hazard_cycles", ph_haz, 5);
        clr_ph();
        i_chk_addr = 8'h77;
        cyc(1, 0, 0, 8'h10, 8'h11, 12'd1, 12'd2);
        cyc(1, 0, 0, 8'h20, 8'h21, 12'd3, 12'd4);
        cyc(1, 0, 0, 8'h30, 8'h33, 12'd5, 12'd6);
        idle(10);
        chk("hazard_unrelated", ph_haz, 0);

        // Up/dn collision: both writes issued, dn value last.
        clr_ph();
        cyc(1, 0, 0, 8'h44, 8'h44, 12'd11, 12'd22);
        idle(3);
        chk("collide_dn_addr", s_waddr, 8'h44);
        chk("collide_dn_data", s_wdata, 12'd22);
        idle(2);

        // Reset with pairs queued and overflow set, then normal traffic.
        for (int k = 0; k < 36; k++) rnd_pair(0, 0);
        do_reset();
        clr_ph();
        for (int k = 0; k < 3; k++) rnd_pair(0, 0);
        idle(10);
        chk("post_reset_writes", ph_we, 6);

        // Randomised traffic with collisions, hazards, tags and resets.
        for (int blk = 0; blk < 20; blk++) begin
            bit gated;
            gated = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 100; k++) begin
                i_chk_addr = AW'($urandom_range(0, 15));
                rst = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 99) < 60 && (!gated || o_ready))
                    cyc(1, 1'($urandom), $urandom_range(0, 49) == 0,
                        AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                        DW'($urandom_range(0, 3328)), DW'($urandom_range(0, 3328)));
                else idle(1);
            end
        end
        rst = 0;
        idle(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
